// File: rtl/kbd_pkg.sv
// Shared types and constants for the keypad matrix scanner.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kbd_state_e;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_SCAN_DIV = 50000;
    localparam int DEF_DEBOUNCE = 4;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_scanner_matrix_scan.sv
// Row scanner: drives one row low per scan slot, synchronises the columns and
// gathers one full frame of key states, reporting the lowest pressed key.
module matrix_scan
    import kbd_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                                clk,
    input  logic                                clr_n,
    input  logic [COLS-1:0]                     col_n,
    output logic [ROWS-1:0]                     row_n,
    output logic                                frame_done,
    output logic                                pressed,
    output logic [code_width(ROWS, COLS)-1:0]   code
);

    localparam int KW = code_width(ROWS, COLS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);

    logic [PW-1:0]             presc_q, presc_d;
    logic [RW-1:0]             row_q, row_d;
    logic [ROWS-1:0]           row_n_q, row_n_d;
    logic [COLS-1:0]           col_s1_q, col_s2_q;
    logic [ROWS-1:0][COLS-1:0] acc_q, acc_d;
    logic                      tc, last_row;

    // Sampling at the end of each row slot gives the synchroniser and the
    // board wiring the whole slot to settle after row_n changes.
    always_comb begin
        tc       = (presc_q == PW'(SCAN_DIV - 1));
        last_row = (row_q == RW'(ROWS - 1));
        presc_d  = tc ? '0 : presc_q + 1'b1;
        row_d    = row_q;
        if (tc) begin
            row_d = last_row ? '0 : row_q + 1'b1;
        end
        row_n_d        = '1;
        row_n_d[row_d] = 1'b0;
        acc_d          = acc_q;
        if (tc) begin
            acc_d[row_q] = ~col_s2_q;
        end
        frame_done = tc && last_row;
        pressed    = |acc_d;
        code       = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                if (acc_d[r][c]) begin
                    code = KW'(r * COLS + c);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_q  <= '0;
            row_q    <= '0;
            row_n_q  <= {{(ROWS - 1){1'b1}}, 1'b0};
            col_s1_q <= '1;
            col_s2_q <= '1;
            acc_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            row_q    <= row_d;
            row_n_q  <= row_n_d;
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
            acc_q    <= acc_d;
        end
    end

    assign row_n = row_n_q;

endmodule

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: per-frame debounce of the scanned key and a single
// emission per press towards the consumer.
module keypad_scanner
    import kbd_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                                clk,
    input  logic                                clr_n,
    output logic [ROWS-1:0]                     row_n,
    input  logic [COLS-1:0]                     col_n,
    output logic [code_width(ROWS, COLS)-1:0]   key_code,
    output logic                                key_valid,
    input  logic                                key_ready,
    output logic                                key_held,
    output logic                                overflow,
    output logic [1:0]                          dbg_state
);

    localparam int KW = code_width(ROWS, COLS);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          frame_done, pressed;
    logic [KW-1:0] code;

    matrix_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .clr_n     (clr_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .frame_done(frame_done),
        .pressed   (pressed),
        .code      (code)
    );

    kbd_state_e    state_q, state_d;
    logic [KW-1:0] cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overflow_q, overflow_d;
    logic          match, confirm, accept;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        confirm = 1'b0;
        match   = pressed && (code == cand_q);
        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        cand_d = code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            state_d = HELD;
                            confirm = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (match) begin
                        cnt_d = cnt_q + 1'b1;
                        if (int'(cnt_q) + 1 >= DEBOUNCE) begin
                            state_d = HELD;
                            confirm = 1'b1;
                        end
                    end else if (pressed) begin
                        cand_d = code;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!match) begin
                        state_d = REL_DB;
                        cnt_d   = CW'(1);
                    end
                end
                REL_DB: begin
                    if (match) begin
                        state_d = HELD;
                    end else if (pressed) begin
                        cand_d = code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            state_d = HELD;
                            confirm = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (int'(cnt_q) + 1 >= DEBOUNCE) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake: a key transfers on a clock edge where key_valid and key_ready
    // are both high. key_valid holds until that transfer, key_code is stable
    // while key_valid is high, and a transfer may coincide with loading the
    // next key. A key confirmed while the previous one is still held back is
    // dropped and latched into the sticky overflow flag.
    always_comb begin
        accept      = key_valid_q && key_ready;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = overflow_q;
        if (confirm) begin
            if (!key_valid_q || accept) begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overflow  = overflow_q;
    assign key_held  = (state_q == HELD) || (state_q == REL_DB);
    assign dbg_state = state_q;

endmodule
